// File: rtl/stream_split.sv
// stream_split: deinterleaves one FIFO stream into x (even samples) and y (odd samples).
// Optional STREAM_SPLIT_BCAST_EN adds a bcast input that copies one word into both outputs.
module stream_split #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in_dout,
  input  logic                 in_empty,
  output logic                 in_rd_en,
`ifdef STREAM_SPLIT_BCAST_EN
  input  logic                 bcast,
`endif
  output logic [DATA_SIZE-1:0] x_out_din,
  output logic                 x_out_wr_en,
  input  logic                 x_out_full,
  output logic [DATA_SIZE-1:0] y_out_din,
  output logic                 y_out_wr_en,
  input  logic                 y_out_full
);

  typedef enum logic {
    S_X = 1'b0,
    S_Y = 1'b1
  } sel_e;

  sel_e                 sel_q;
  sel_e                 sel_d;
  logic                 x_valid_q;
  logic                 x_valid_d;
  logic                 y_valid_q;
  logic                 y_valid_d;
  logic [DATA_SIZE-1:0] x_hold_q;
  logic [DATA_SIZE-1:0] x_hold_d;
  logic [DATA_SIZE-1:0] y_hold_q;
  logic [DATA_SIZE-1:0] y_hold_d;

  logic bcast_c;
  logic x_free;
  logic y_free;
  logic tgt_free;
  logic load_x;
  logic load_y;

`ifdef STREAM_SPLIT_BCAST_EN
  always_comb bcast_c = bcast;
`else
  always_comb bcast_c = 1'b0;
`endif

  // State register for the read-target selector.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_q <= S_X;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Target toggles only on an alternating read; broadcast reads leave it alone.
  always_comb begin
    sel_d = sel_q;
    if (in_rd_en && !bcast_c) begin
      sel_d = (sel_q == S_X) ? S_Y : S_X;
    end
  end

  // Strobes and flow control; a slot draining this cycle counts as free.
  always_comb begin
    x_out_wr_en = 1'b0;
    y_out_wr_en = 1'b0;
    x_out_din   = '0;
    y_out_din   = '0;
    in_rd_en    = 1'b0;
    x_free      = 1'b0;
    y_free      = 1'b0;
    tgt_free    = 1'b0;
    load_x      = 1'b0;
    load_y      = 1'b0;

    x_out_wr_en = reset && x_valid_q && !x_out_full;
    y_out_wr_en = reset && y_valid_q && !y_out_full;
    x_out_din   = x_out_wr_en ? x_hold_q : '0;
    y_out_din   = y_out_wr_en ? y_hold_q : '0;

    x_free   = !x_valid_q || x_out_wr_en;
    y_free   = !y_valid_q || y_out_wr_en;
    tgt_free = (sel_q == S_X) ? x_free : y_free;

    in_rd_en = reset && !in_empty && (bcast_c ? (x_free && y_free) : tgt_free);
    load_x   = in_rd_en && (bcast_c || (sel_q == S_X));
    load_y   = in_rd_en && (bcast_c || (sel_q == S_Y));
  end

  // Holding-register next state: drain clears, a refill in the same cycle wins.
  always_comb begin
    x_valid_d = x_valid_q;
    y_valid_d = y_valid_q;
    x_hold_d  = x_hold_q;
    y_hold_d  = y_hold_q;

    if (x_out_wr_en) x_valid_d = 1'b0;
    if (y_out_wr_en) y_valid_d = 1'b0;

    if (load_x) begin
      x_hold_d  = in_dout;
      x_valid_d = 1'b1;
    end
    if (load_y) begin
      y_hold_d  = in_dout;
      y_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      x_valid_q <= 1'b0;
      y_valid_q <= 1'b0;
      x_hold_q  <= '0;
      y_hold_q  <= '0;
    end else begin
      x_valid_q <= x_valid_d;
      y_valid_q <= y_valid_d;
      x_hold_q  <= x_hold_d;
      y_hold_q  <= y_hold_d;
    end
  end

endmodule
